// File: rtl/boot_rom_pipe.sv
// boot_rom_pipe: read-only boot image served through a fixed-latency pipeline.
// Requests are credit limited, responses return in order through a small
// FIFO with backpressure, and addresses outside the image return an error.
module boot_rom_pipe #(
  parameter int DATA_WIDTH                        = 64,
  parameter int ADDR_WIDTH                        = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 'h1000,
  parameter int NUM_WORDS                         = 4,
  parameter logic [DATA_WIDTH-1:0] ROM_IMAGE [NUM_WORDS] = '{
    64'h00a2a02345056291,
    64'h0202859302fe4285,
    64'h00028067f1402573,
    64'h0000000000000000
  },
  parameter int LATENCY                           = 1,
  parameter int MAX_OUTSTANDING                   = 2
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic                                     req_i,
  input  logic [ADDR_WIDTH-1:0]                    address_i,
  output logic                                     grant_o,
  output logic                                     rvalid_o,
  input  logic                                     rready_i,
  output logic [DATA_WIDTH-1:0]                    rdata_o,
  output logic                                     rerr_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding_o
);

  localparam int BYTES   = DATA_WIDTH / 8;
  localparam int BYTE_SH = $clog2(BYTES);
  localparam int CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  localparam logic [CNT_W-1:0]      MAX_CNT     = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0]      LAST_PTR    = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [ADDR_WIDTH-1:0] NUM_WORDS_A = ADDR_WIDTH'(NUM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK  = ADDR_WIDTH'(BYTES - 1);

  // Request side
  logic                  accept;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  in_range;
  logic [DATA_WIDTH-1:0] dec_data;
  logic                  dec_err;

  // Value arriving at the FIFO write port
  logic                  wr_valid;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_err;

  // Outstanding credit counter
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;

  // Response FIFO
  logic [DATA_WIDTH-1:0] fifo_data_q [MAX_OUTSTANDING];
  logic [DATA_WIDTH-1:0] fifo_data_d [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] fifo_err_q, fifo_err_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic                  hold_err_q, hold_err_d;

  // Grant only while credits remain; the check uses the registered count so
  // rready_i never reaches grant_o combinationally.
  assign grant_o       = req_i && (out_cnt_q < MAX_CNT);
  assign accept        = req_i && grant_o;
  assign rvalid_o      = (fifo_cnt_q != '0);
  assign pop           = rvalid_o && rready_i;
  assign outstanding_o = out_cnt_q;
  assign rdata_o       = rvalid_o ? fifo_data_q[rd_ptr_q] : hold_data_q;
  assign rerr_o        = rvalid_o ? fifo_err_q[rd_ptr_q]  : hold_err_q;

  // Decode the request address into ROM data or an address error.
  always_comb begin
    offset   = address_i - BASE_ADDR;
    word_idx = offset >> BYTE_SH;
    in_range = (address_i >= BASE_ADDR) && (word_idx < NUM_WORDS_A);
    dec_data = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (in_range && (word_idx == ADDR_WIDTH'(k))) begin
        dec_data = ROM_IMAGE[k];
      end
    end
    dec_err = !in_range;
  end

  // The final latency stage is the FIFO write itself, so LATENCY-1 register
  // stages sit between the decode and the FIFO.
  if (LATENCY == 1) begin : g_no_stage
    assign wr_valid = accept;
    assign wr_data  = dec_data;
    assign wr_err   = dec_err;
  end else begin : g_stages
    localparam int STAGES = LATENCY - 1;

    logic [STAGES-1:0]     stg_valid_q, stg_valid_d;
    logic [STAGES-1:0]     stg_err_q, stg_err_d;
    logic [DATA_WIDTH-1:0] stg_data_q [STAGES];
    logic [DATA_WIDTH-1:0] stg_data_d [STAGES];

    // Shift the decoded request one stage per cycle; the pipeline never stalls.
    always_comb begin
      stg_valid_d[0] = accept;
      stg_err_d[0]   = dec_err;
      stg_data_d[0]  = dec_data;
      for (int k = 1; k < STAGES; k++) begin
        stg_valid_d[k] = stg_valid_q[k-1];
        stg_err_d[k]   = stg_err_q[k-1];
        stg_data_d[k]  = stg_data_q[k-1];
      end
    end

    // Pipeline registers; only the valid bits matter after reset.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        stg_valid_q <= '0;
        stg_err_q   <= '0;
        for (int k = 0; k < STAGES; k++) stg_data_q[k] <= '0;
      end else begin
        stg_valid_q <= stg_valid_d;
        stg_err_q   <= stg_err_d;
        for (int k = 0; k < STAGES; k++) stg_data_q[k] <= stg_data_d[k];
      end
    end

    assign wr_valid = stg_valid_q[STAGES-1];
    assign wr_data  = stg_data_q[STAGES-1];
    assign wr_err   = stg_err_q[STAGES-1];
  end

  // Credits: taken on accept, returned on pop, net zero when both happen.
  always_comb begin
    out_cnt_d = out_cnt_q;
    case ({accept, pop})
      2'b10:   out_cnt_d = out_cnt_q + 1'b1;
      2'b01:   out_cnt_d = out_cnt_q - 1'b1;
      default: out_cnt_d = out_cnt_q;
    endcase
  end

  // Response FIFO next state; the hold registers keep the last shown head.
  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_err_d  = fifo_err_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fifo_cnt_d  = fifo_cnt_q;
    hold_data_d = rdata_o;
    hold_err_d  = rerr_o;
    if (wr_valid) begin
      fifo_data_d[wr_ptr_q] = wr_data;
      fifo_err_d[wr_ptr_q]  = wr_err;
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({wr_valid, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // State registers for credits, FIFO and hold values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_cnt_q   <= '0;
      fifo_err_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      hold_data_q <= '0;
      hold_err_q  <= 1'b0;
      for (int k = 0; k < MAX_OUTSTANDING; k++) fifo_data_q[k] <= '0;
    end else begin
      out_cnt_q   <= out_cnt_d;
      fifo_err_q  <= fifo_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      hold_data_q <= hold_data_d;
      hold_err_q  <= hold_err_d;
      for (int k = 0; k < MAX_OUTSTANDING; k++) fifo_data_q[k] <= fifo_data_d[k];
    end
  end

`ifndef SYNTHESIS
  // Parameter sanity and credit/FIFO invariants.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (LATENCY >= 1 && LATENCY <= 4);
      assert ((BASE_ADDR & ALIGN_MASK) == '0);
      assert (!(wr_valid && (fifo_cnt_q == MAX_CNT)));
      assert (!(pop && (fifo_cnt_q == '0)));
      assert (out_cnt_q <= MAX_CNT);
    end
  end
`endif

endmodule

// File: tb/tb_boot_rom_pipe.sv
// tb_boot_rom_pipe: drives two boot_rom_pipe instances (default image with
// LATENCY=1, and a 32-bit LATENCY=3 variant) against a queue-based model.
module tb_boot_rom_pipe;

  localparam int MAXO_A = 2;
  localparam int MAXO_B = 4;
  localparam int LAT_A  = 1;
  localparam int LAT_B  = 3;

  typedef struct {
    int          sel;
    logic [63:0] data;
    bit          err;
    int          ready_at;
  } resp_t;

  logic clk = 1'b0;
  logic rst_n;

  logic        a_req, a_grant, a_rvalid, a_rready, a_rerr;
  logic [63:0] a_addr, a_rdata;
  logic [1:0]  a_outst;

  logic        b_req, b_grant, b_rvalid, b_rready, b_rerr;
  logic [31:0] b_addr, b_rdata;
  logic [2:0]  b_outst;

  int          compared   = 0;
  int          mismatched = 0;
  int          edge_cnt   = 0;
  resp_t       model_q[$];
  logic [63:0] last_data [2];
  bit          last_err  [2];
  logic [63:0] img_a [4];
  logic [63:0] img_b [4];

  always #5 clk = ~clk;

  boot_rom_pipe dut_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(a_req), .address_i(a_addr),
    .grant_o(a_grant), .rvalid_o(a_rvalid), .rready_i(a_rready),
    .rdata_o(a_rdata), .rerr_o(a_rerr), .outstanding_o(a_outst)
  );

  boot_rom_pipe #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .BASE_ADDR(32'h8000), .NUM_WORDS(4),
    .ROM_IMAGE('{32'hdeadbeef, 32'h0badf00d, 32'hcafe1234, 32'h8badc0de}),
    .LATENCY(LAT_B), .MAX_OUTSTANDING(MAXO_B)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(b_req), .address_i(b_addr),
    .grant_o(b_grant), .rvalid_o(b_rvalid), .rready_i(b_rready),
    .rdata_o(b_rdata), .rerr_o(b_rerr), .outstanding_o(b_outst)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference decode straight from the address rules, in plain arithmetic.
  task automatic refDecode(input int s, input logic [63:0] addr,
                           output logic [63:0] data, output bit err);
    logic [63:0] a, base, bytes, idx;
    a     = (s == 1) ? {32'h0, addr[31:0]} : addr;
    base  = (s == 1) ? 64'h8000 : 64'h1000;
    bytes = (s == 1) ? 64'd4 : 64'd8;
    data  = '0;
    err   = 1'b1;
    if (a >= base) begin
      idx = (a - base) / bytes;
      if (idx < 64'd4) begin
        data = (s == 1) ? img_b[idx[1:0]] : img_a[idx[1:0]];
        err  = 1'b0;
      end
    end
  endtask

  function automatic int headIdx(input int s);
    for (int i = 0; i < model_q.size(); i++) if (model_q[i].sel == s) return i;
    return -1;
  endfunction

  function automatic int countOf(input int s);
    int n = 0;
    for (int i = 0; i < model_q.size(); i++) if (model_q[i].sel == s) n++;
    return n;
  endfunction

  function automatic logic [63:0] randAddr(input int s);
    logic [63:0] base, bytes;
    int r;
    base  = (s == 1) ? 64'h8000 : 64'h1000;
    bytes = (s == 1) ? 64'd4 : 64'd8;
    r = $urandom_range(0, 9);
    if (r == 0) return 64'hffff_ffff_ffff_fff8;
    if (r == 1) return base - bytes;
    return base + bytes * 64'($urandom_range(0, 4)) + 64'($urandom_range(0, 32'(bytes) - 1));
  endfunction

  // Compare one DUT's outputs against the model and report this cycle's accept/pop.
  task automatic checkOutput(input int s, input bit req, input bit rdy,
                             output bit acc, output bit pp);
    int h, n, maxo;
    bit exp_rv, exp_e, exp_g;
    logic [63:0] exp_d;
    string p;
    h    = headIdx(s);
    n    = countOf(s);
    maxo = (s == 1) ? MAXO_B : MAXO_A;
    p    = (s == 1) ? "B" : "A";
    exp_rv = (h >= 0) && (model_q[h].ready_at <= edge_cnt);
    exp_d  = exp_rv ? model_q[h].data : last_data[s];
    exp_e  = exp_rv ? model_q[h].err  : last_err[s];
    exp_g  = req && (n < maxo);
    if (s == 0) begin
      chk({p, ".grant"},  64'(a_grant),  64'(exp_g));
      chk({p, ".rvalid"}, 64'(a_rvalid), 64'(exp_rv));
      chk({p, ".rdata"},  a_rdata,       exp_d);
      chk({p, ".rerr"},   64'(a_rerr),   64'(exp_e));
      chk({p, ".outst"},  64'(a_outst),  64'(n));
    end else begin
      chk({p, ".grant"},  64'(b_grant),  64'(exp_g));
      chk({p, ".rvalid"}, 64'(b_rvalid), 64'(exp_rv));
      chk({p, ".rdata"},  64'(b_rdata),  exp_d);
      chk({p, ".rerr"},   64'(b_rerr),   64'(exp_e));
      chk({p, ".outst"},  64'(b_outst),  64'(n));
    end
    last_data[s] = exp_d;
    last_err[s]  = exp_e;
    acc = exp_g;
    pp  = exp_rv && rdy;
  endtask

  // One clock cycle: drive both DUTs, check, then advance the model at the edge.
  task automatic applyStimulus(input bit req0, input logic [63:0] addr0, input bit rdy0,
                               input bit req1, input logic [63:0] addr1, input bit rdy1);
    bit acc0, acc1, pop0, pop1;
    resp_t r;
    int h;
    @(negedge clk);
    a_req = req0; a_addr = addr0;       a_rready = rdy0;
    b_req = req1; b_addr = addr1[31:0]; b_rready = rdy1;
    #1;
    checkOutput(0, req0, rdy0, acc0, pop0);
    checkOutput(1, req1, rdy1, acc1, pop1);
    @(posedge clk);
    edge_cnt++;
    if (pop0) begin h = headIdx(0); model_q.delete(h); end
    if (pop1) begin h = headIdx(1); model_q.delete(h); end
    if (acc0) begin
      r.sel = 0; r.ready_at = edge_cnt + LAT_A - 1;
      refDecode(0, addr0, r.data, r.err);
      model_q.push_back(r);
    end
    if (acc1) begin
      r.sel = 1; r.ready_at = edge_cnt + LAT_B - 1;
      refDecode(1, addr1, r.data, r.err);
      model_q.push_back(r);
    end
  endtask

  task automatic idleA(input int cycles);
    repeat (cycles) applyStimulus(1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1);
  endtask

  task automatic doReset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    a_req = 1'b0; b_req = 1'b0;
    repeat (cycles) @(posedge clk);
    model_q.delete();
    last_data[0] = '0; last_data[1] = '0;
    last_err[0]  = 1'b0; last_err[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    img_a[0] = 64'h00a2a02345056291; img_a[1] = 64'h0202859302fe4285;
    img_a[2] = 64'h00028067f1402573; img_a[3] = 64'h0;
    img_b[0] = 64'hdeadbeef; img_b[1] = 64'h0badf00d;
    img_b[2] = 64'hcafe1234; img_b[3] = 64'h8badc0de;
    rst_n = 1'b0;
    a_req = 1'b0; a_addr = '0; a_rready = 1'b0;
    b_req = 1'b0; b_addr = '0; b_rready = 1'b0;

    $display("[TB] reset then idle");
    doReset(2);
    idleA(2);

    $display("[TB] default image sweep");
    applyStimulus(1'b1, 64'h1000, 1'b1, 1'b0, 64'h0, 1'b1);
    applyStimulus(1'b1, 64'h1008, 1'b1, 1'b0, 64'h0, 1'b1);
    applyStimulus(1'b1, 64'h1010, 1'b1, 1'b0, 64'h0, 1'b1);
    applyStimulus(1'b1, 64'h1018, 1'b1, 1'b0, 64'h0, 1'b1);
    idleA(2);

    $display("[TB] out of range interleaved");
    applyStimulus(1'b1, 64'h0ff8, 1'b1, 1'b0, 64'h0, 1'b1);
    applyStimulus(1'b1, 64'h1008, 1'b1, 1'b0, 64'h0, 1'b1);
    applyStimulus(1'b1, 64'h1020, 1'b1, 1'b0, 64'h0, 1'b1);
    applyStimulus(1'b1, 64'h1008, 1'b1, 1'b0, 64'h0, 1'b1);
    applyStimulus(1'b1, 64'hffff_ffff_ffff_fff8, 1'b1, 1'b0, 64'h0, 1'b1);
    idleA(2);

    $display("[TB] backpressure");
    applyStimulus(1'b1, 64'h1000, 1'b0, 1'b0, 64'h0, 1'b1);
    applyStimulus(1'b1, 64'h1008, 1'b0, 1'b0, 64'h0, 1'b1);
    applyStimulus(1'b1, 64'h1010, 1'b0, 1'b0, 64'h0, 1'b1);
    applyStimulus(1'b1, 64'h1010, 1'b1, 1'b0, 64'h0, 1'b1);
    applyStimulus(1'b1, 64'h1018, 1'b1, 1'b0, 64'h0, 1'b1);
    idleA(3);

    $display("[TB] latency 3, 32-bit image");
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b1, 64'h8006, 1'b1);
    idleA(4);
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b1, 64'h8000, 1'b1);
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b1, 64'h8004, 1'b1);
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b1, 64'h800b, 1'b1);
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b1, 64'h800c, 1'b1);
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b1, 64'h8010, 1'b1);
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b1, 64'h7ffc, 1'b1);
    idleA(5);

    $display("[TB] reset mid-operation");
    applyStimulus(1'b1, 64'h1000, 1'b0, 1'b1, 64'h8000, 1'b0);
    applyStimulus(1'b1, 64'h1008, 1'b0, 1'b1, 64'h8004, 1'b0);
    doReset(1);
    idleA(6);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 9) < 6), randAddr(0), ($urandom_range(0, 9) < 7),
                    ($urandom_range(0, 9) < 6), randAddr(1), ($urandom_range(0, 9) < 7));
    end
    idleA(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/boot_rom_pipe.md
Name: boot_rom_pipe

Overview:
Parametrised boot ROM for the core's boot path. It serves read-only words from a parameter image at a configurable base address. Read latency is configurable, outstanding requests are bounded, the response side has backpressure, and out-of-range accesses return an error response. It sits on the instruction/data fetch port at the reset vector region.

Parameters:
DATA_WIDTH, 64, word width in bits (power of two, 32 or 64)
ADDR_WIDTH, 64, request address width
BASE_ADDR, 64'h1000, byte address of word 0 (aligned to DATA_WIDTH/8)
NUM_WORDS, 4, number of ROM words (>=1)
ROM_IMAGE, {64'h00a2a02345056291, 64'h0202859302fe4285, 64'h00028067f1402573, 64'h0}, unpacked array [NUM_WORDS] of DATA_WIDTH contents, index 0 at BASE_ADDR
LATENCY, 1, cycles from grant to earliest rvalid (1..4)
MAX_OUTSTANDING, 2, granted-but-not-consumed request limit (>=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset: synchronous, active-low
req_i  in  1  request valid
address_i  in  ADDR_WIDTH  byte address; low log2(DATA_WIDTH/8) bits ignored
grant_o  out  1  request accepted this cycle (combinational)
rvalid_o  out  1  response valid
rready_i  in  1  response consumed when high with rvalid_o
rdata_o  out  DATA_WIDTH  response data
rerr_o  out  1  response is an address error
outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  current outstanding count

Behaviour:
- Reset, sampled on posedge clk_i with rst_ni=0: pipeline valid bits, FIFO pointers and outstanding counter cleared. Outputs after reset: rvalid_o=0, rdata_o=0, rerr_o=0, outstanding_o=0. Any in-flight request is discarded with no response.
- Grant: grant_o = req_i && (outstanding < MAX_OUTSTANDING). There is no dependence on rready_i. Accepted request = req_i && grant_o.
- Decode: word index = (address_i - BASE_ADDR) >> log2(DATA_WIDTH/8).
  - In range iff address_i >= BASE_ADDR and index < NUM_WORDS. Compare at full ADDR_WIDTH with no wrap-around, so an address below BASE_ADDR is out of range.
  - In range: data = ROM_IMAGE[index], err = 0. Out of range: data = 0, err = 1.
- Pipeline: LATENCY register stages carry {valid, data, err}. Stage 1 loads the accepted request's decode. Each stage advances every cycle, so the pipeline never stalls.
- Response FIFO: depth MAX_OUTSTANDING. Written from the last stage when valid.
  - Overflow cannot occur; the credit limit guarantees it, and the bench asserts it.
  - rvalid_o = FIFO not empty; rdata_o and rerr_o show the FIFO head. Pop on rvalid_o && rready_i. Responses stay in request order.
  - FIFO empty: rvalid_o=0 and rdata_o/rerr_o hold their last value (0 after reset).
- Latency: with rready_i held high, an accepted request at edge N gives rvalid_o high in the cycle after edge N+LATENCY-1, i.e. LATENCY cycles after grant. FIFO bypass is not allowed; the FIFO write adds no extra cycle because the last pipeline stage is the FIFO write port.
- Outstanding counter: +1 on accept, -1 on pop, unchanged when both occur in the same cycle. Range is 0..MAX_OUTSTANDING.
- Full: at outstanding=MAX_OUTSTANDING, grant_o=0 even if a pop occurs that cycle. No combinational path from rready_i to grant_o.
- Back-to-back: one accept per cycle is sustained when MAX_OUTSTANDING >= LATENCY+1 and rready_i is held high.
- Assertions required in RTL (bench-enabled):
  - no FIFO write when full;
  - no pop when empty;
  - outstanding never exceeds MAX_OUTSTANDING;
  - parameter checks: LATENCY in 1..4, BASE_ADDR aligned.

Test Plan:
- Reset then idle: rst_ni=0 for 2 cycles, then 1 -> rvalid_o=0, grant_o=0 while req_i=0, outstanding_o=0.
- Default image sweep, rready_i=1: requests to 0x1000, 0x1008, 0x1010, 0x1018 on consecutive cycles -> rvalid 1 cycle after each grant. Data 00a2a02345056291, 0202859302fe4285, 00028067f1402573, 0, in order, rerr_o=0.
- Out of range: requests to 0x0ff8, 0x1020 and 0xffff_ffff_ffff_fff8 -> rerr_o=1, rdata_o=0, order kept relative to interleaved 0x1008 (data 0202859302fe4285).
- Backpressure, MAX_OUTSTANDING=2, rready_i=0, req_i held high -> exactly 2 grants, then grant_o=0. Raise rready_i for 1 cycle -> one pop, no grant that cycle, grant_o=1 the next cycle.
- LATENCY=3, DATA_WIDTH=32, BASE_ADDR=0x8000, 4-entry image -> rvalid_o exactly 3 cycles after grant. Request to 0x8006 returns word 1 (low bits ignored).
- Reset mid-operation: 2 requests outstanding, pull rst_ni low for 1 cycle -> next cycle rvalid_o=0, outstanding_o=0, and no stale response ever appears afterwards.
